bnn_vad_core: RTL and testbench

Parametrised binarized-neural-network voice-activity classifier: accepts one packed feature frame over a valid/ready handshake, splits it into `N_CHUNK` chunks, runs `N_FILT` binary (XNOR-popcount) filters per chunk, accumulates `N_CLASS` XNOR-popcount class scores, and returns the argmax class over a valid/ready output handshake. It is the successor to the fixed 20-bit, 3-filter, 2-class fetch/conv/binarize/MAC/compare chain and sits between the frame feature extractor and the VAD decision consumer.

---
 rtl/bnn_vad_core.sv | 167 ++++++++++++++++
 tb/tb_bnn_vad_core.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/bnn_vad_core.sv
// Binarized-network voice-activity classifier: XNOR-popcount filters per chunk, class scoring, argmax.
// Optional hangover smoothing of the decision is enabled by defining BNN_VAD_HANGOVER_EN.
module bnn_vad_core #(
    parameter int CHUNK_W = 5,
    parameter int N_CHUNK = 4,
    parameter int N_FILT  = 3,
    parameter int N_CLASS = 2,
    parameter int CONV_TH = 3,
    parameter logic [N_FILT*CHUNK_W-1:0] CONV_W = '1,
    parameter logic [N_CLASS*N_CHUNK*N_FILT-1:0] FC_W =
        {{(N_CHUNK*N_FILT){1'b1}}, {(N_CHUNK*N_FILT){1'b0}}},
    parameter int HANG    = 2,
    localparam int FRAME_W = CHUNK_W*N_CHUNK,
    localparam int RES_W   = $clog2(N_CLASS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FRAME_W-1:0] data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RES_W-1:0]   result
);

    localparam int SCORE_W = $clog2(N_CHUNK*N_FILT+1);
    localparam int CNT_W   = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DECIDE, DONE} state_t;

    state_t               state;
    logic [FRAME_W-1:0]   frame_q;
    logic [CNT_W-1:0]     chunk_cnt;
    logic [SCORE_W-1:0]   score_q   [N_CLASS];
    logic [CHUNK_W-1:0]   chunk_arr [N_CHUNK];
    logic [N_FILT-1:0]    fc_arr    [N_CLASS][N_CHUNK];
    logic [CHUNK_W-1:0]   cur_chunk;
    logic [N_FILT-1:0]    feat;
    logic [SCORE_W-1:0]   score_inc [N_CLASS];
    logic [SCORE_W-1:0]   best_score;
    logic [RES_W-1:0]     best_idx;
    logic [RES_W-1:0]     next_result;

    function automatic int ones_chunk(input logic [CHUNK_W-1:0] v);
        int s;
        s = 0;
        for (int i = 0; i < CHUNK_W; i++) s += int'(v[i]);
        return s;
    endfunction

    function automatic logic [SCORE_W-1:0] ones_feat(input logic [N_FILT-1:0] v);
        logic [SCORE_W-1:0] s;
        s = '0;
        for (int i = 0; i < N_FILT; i++) s = s + SCORE_W'(v[i]);
        return s;
    endfunction

    // Constant slices of the frame and class weights, so the runtime chunk index only drives a mux
    for (genvar c = 0; c < N_CHUNK; c++) begin : g_chunk
        assign chunk_arr[c] = frame_q[c*CHUNK_W +: CHUNK_W];
        for (genvar k = 0; k < N_CLASS; k++) begin : g_fc
            assign fc_arr[k][c] = FC_W[(k*N_CHUNK+c)*N_FILT +: N_FILT];
        end
    end

    assign cur_chunk = chunk_arr[chunk_cnt];

    always_comb begin
        feat = '0;
        for (int f = 0; f < N_FILT; f++)
            feat[f] = (ones_chunk(~(cur_chunk ^ CONV_W[f*CHUNK_W +: CHUNK_W])) >= CONV_TH);
        for (int k = 0; k < N_CLASS; k++)
            score_inc[k] = ones_feat(~(feat ^ fc_arr[k][chunk_cnt]));
    end

    // Only a strictly larger score displaces the leader, so ties keep the lowest index
    always_comb begin
        best_idx   = '0;
        best_score = score_q[0];
        for (int k = 1; k < N_CLASS; k++) begin
            if (score_q[k] > best_score) begin
                best_score = score_q[k];
                best_idx   = RES_W'(k);
            end
        end
    end

`ifdef BNN_VAD_HANGOVER_EN
    localparam int HC_W = (HANG > 0) ? $clog2(HANG+1) : 1;

    logic [HC_W-1:0]  hang_cnt;
    logic [RES_W-1:0] last_nz;

    always_comb begin
        if (best_idx != '0)
            next_result = best_idx;
        else if (hang_cnt != '0)
            next_result = last_nz;
        else
            next_result = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hang_cnt <= '0;
            last_nz  <= '0;
        end else if (state == DECIDE) begin
            if (best_idx != '0) begin
                hang_cnt <= HC_W'(HANG);
                last_nz  <= best_idx;
            end else if (hang_cnt != '0) begin
                hang_cnt <= hang_cnt - HC_W'(1);
            end
        end
    end
`else
    assign next_result = best_idx;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            frame_q   <= '0;
            chunk_cnt <= '0;
            for (int k = 0; k < N_CLASS; k++) score_q[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        frame_q   <= data_in;
                        chunk_cnt <= '0;
                        for (int k = 0; k < N_CLASS; k++) score_q[k] <= '0;
                        in_ready  <= 1'b0;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    for (int k = 0; k < N_CLASS; k++) score_q[k] <= score_q[k] + score_inc[k];
                    if (chunk_cnt == CNT_W'(N_CHUNK-1))
                        state <= DECIDE;
                    else
                        chunk_cnt <= chunk_cnt + CNT_W'(1);
                end
                DECIDE: begin
                    result    <= next_result;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_vad_core.sv
// Directed bench for bnn_vad_core: default-weight instance plus a tied-weight instance run in lockstep.
module tb_bnn_vad_core;

`ifdef BNN_VAD_HANGOVER_EN
    localparam bit HANG_EN = 1'b1;
`else
    localparam bit HANG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [19:0] data_in;
    logic        in_ready, out_valid;
    logic [0:0]  result;
    logic        in_ready_t, out_valid_t;
    logic [0:0]  result_t;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    bnn_vad_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    bnn_vad_core #(.FC_W(24'hFFFFFF)) dut_tie (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_t),
        .data_in   (data_in),
        .out_valid (out_valid_t),
        .out_ready (out_ready),
        .result    (result_t)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Offer one frame, step through the accept edge, then count edges until out_valid rises
    task automatic applyStimulus(input logic [19:0] frame, output int latency);
        int n;
        data_in  = frame;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step;
            n++;
        end
        checkOutput("accept ready", 32'(in_ready), 32'd1);
        step;
        in_valid = 1'b0;
        latency  = 0;
        while (!out_valid && latency < 30) begin
            step;
            latency++;
        end
    endtask

    task automatic runFrame(input string tag, input logic [19:0] frame, input logic expected);
        int lat;
        out_ready = 1'b1;
        applyStimulus(frame, lat);
        checkOutput({tag, " latency"}, 32'(lat), 32'd5);
        checkOutput({tag, " result"}, 32'(result), 32'(expected));
        checkOutput({tag, " tie result"}, 32'(result_t), 32'd0);
        checkOutput({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
        step;
        checkOutput({tag, " out_valid cleared"}, 32'(out_valid), 32'd0);
        checkOutput({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int          lat;
        logic        seen;
        logic [19:0] hang_frames [4];
        logic        hang_exp    [4];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data_in   = '0;
        repeat (3) step;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset result", 32'(result), 32'd0);
        rst_n = 1'b1;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);

        // Class-0 frames first, so hangover state (if built in) is still clear
        runFrame("zeros", 20'h00000, 1'b0);
        runFrame("two of four chunks fire", 20'h07C67, 1'b0);
        runFrame("popcount 2 chunks", 20'h294A5, 1'b0);
        runFrame("ones", 20'hFFFFF, 1'b1);
        runFrame("popcount 3 chunks", 20'hAD6B5, 1'b1);
        runFrame("three of four fire", 20'h5FC67, 1'b1);

        out_ready = 1'b0;
        applyStimulus(20'hFFFFF, lat);
        checkOutput("bp latency", 32'(lat), 32'd5);
        in_valid = 1'b1;
        data_in  = 20'h00000;
        for (int i = 0; i < 10; i++) begin
            step;
            checkOutput("bp result hold", 32'(result), 32'd1);
            checkOutput("bp out_valid hold", 32'(out_valid), 32'd1);
            checkOutput("bp in_ready low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step;
        checkOutput("bp handshake out_valid", 32'(out_valid), 32'd0);
        checkOutput("bp handshake in_ready", 32'(in_ready), 32'd1);
        applyStimulus(20'h00000, lat);
        checkOutput("bp second latency", 32'(lat), 32'd5);
        checkOutput("bp second result", 32'(result), HANG_EN ? 32'd1 : 32'd0);
        step;
        checkOutput("bp second done", 32'(out_valid), 32'd0);

        checkOutput("midrst ready", 32'(in_ready), 32'd1);
        data_in  = 20'hFFFFF;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step;
            if (out_valid) seen = 1'b1;
        end
        checkOutput("midrst no result", 32'(seen), 32'd0);
        runFrame("after midrst", 20'hFFFFF, 1'b1);

        hang_frames = '{20'hFFFFF, 20'h00000, 20'h00000, 20'h00000};
        if (HANG_EN) hang_exp = '{1'b1, 1'b1, 1'b1, 1'b0};
        else         hang_exp = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++)
            runFrame($sformatf("hang seq %0d", i), hang_frames[i], hang_exp[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
